ram_word_seq: RTL and testbench

Bit-serial word sequencer between the datapath and the 64 x 1-bit data RAM. Accepts one word read or write request. Walks WORD_W consecutive RAM addresses, one bit per cycle, LSB at the base address. Assembles read bits into a word, or serialises write data onto the RAM's single data/store pins, then returns a one-cycle response.

---
 rtl/ram_word_seq_pkg.sv | 19 +
 rtl/ram_seq_shifter.sv | 61 ++++++
 rtl/ram_word_seq.sv | 138 +++++++++++++
 tb/tb_ram_word_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_word_seq_pkg.sv
// Shared types and default sizes for the bit-serial RAM word sequencer.
// Optional feature macro: RAM_WORD_SEQ_VERIFY_EN (adds the VERIFY state).
package ram_word_seq_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;

  // Fixed encodings keep state values stable across builds with and without verify.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WRITE  = 3'd2,
`ifdef RAM_WORD_SEQ_VERIFY_EN
    ST_VERIFY = 3'd3,
`endif
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/ram_seq_shifter.sv
// Word shift register plus bit counter for the RAM word sequencer.
// Write data rotates through bit 0 so it is intact again for a verify pass;
// read data enters at the MSB so the first bit read ends up at bit 0.
module ram_seq_shifter
  import ram_word_seq_pkg::*;
#(
  parameter  int WORD_W = WORD_W_DEF,
  localparam int CNT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              load_i,       // accept: load word, restart count
  input  logic [WORD_W-1:0] load_word_i,
  input  logic              step_i,       // advance one bit
  input  logic              rotate_i,     // 1: recirculate bit 0, 0: shift in bit_i
  input  logic              bit_i,
  output logic              cur_bit_o,
  output logic              last_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [WORD_W-1:0] word_next_o   // register contents after this step
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_bit;

  assign cur_bit_o   = shreg_q[0];
  assign cnt_o       = cnt_q;
  assign last_o      = (cnt_q == CNT_W'(WORD_W - 1));
  assign in_bit      = rotate_i ? shreg_q[0] : bit_i;
  // Shift form works for WORD_W = 1 as well, where a part-select would not.
  assign word_next_o = (shreg_q >> 1) | (WORD_W'(in_bit) << (WORD_W - 1));

  // Next-state: load on accept, otherwise shift and count while stepping.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = load_word_i;
      cnt_d   = '0;
    end else if (step_i) begin
      shreg_d = word_next_o;
      cnt_d   = last_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      // NOTE: the word register is a plain flop vector, so clearing it is cheap and required here.
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_word_seq.sv
// Bit-serial word sequencer between the datapath and a 2^ADDR_W x 1 RAM.
// One request walks WORD_W consecutive addresses (wrapping), LSB at base.
// Optional feature macro: RAM_WORD_SEQ_VERIFY_EN (write read-back verify, rsp_err).
module ram_word_seq
  import ram_word_seq_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_datain,
  output logic              ram_store,
  input  logic              ram_dataout
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              active;
  logic              load;
  logic              cur_bit;
  logic              last;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] word_next;

`ifdef RAM_WORD_SEQ_VERIFY_EN
  logic err_q, err_d;
  logic mismatch;
  assign active   = (state_q == ST_READ) || (state_q == ST_WRITE) || (state_q == ST_VERIFY);
  assign mismatch = (state_q == ST_VERIFY) && (cur_bit != ram_dataout);
  assign rsp_err  = err_q;
`else
  assign active   = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign rsp_err  = 1'b0;
`endif

  assign load      = (state_q == ST_IDLE) && req_valid;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_rdata = rdata_q;

  // RAM pins are parked at 0 outside an active walk. Store is also gated by
  // clear_n so a reset edge landing mid-write never commits that cycle's bit.
  assign ram_address = active ? base_q + ADDR_W'(cnt) : '0;
  assign ram_datain  = (state_q == ST_WRITE) ? cur_bit : 1'b0;
  assign ram_store   = (state_q == ST_WRITE) && clear_n;

  ram_seq_shifter #(.WORD_W(WORD_W)) u_shifter (
    .clk         (clk),
    .clear_n     (clear_n),
    .load_i      (load),
    .load_word_i (req_write ? req_wdata : '0),
    .step_i      (active),
    .rotate_i    (state_q != ST_READ),
    .bit_i       (ram_dataout),
    .cur_bit_o   (cur_bit),
    .last_o      (last),
    .cnt_o       (cnt),
    .word_next_o (word_next)
  );

  // Sequencer FSM next-state and response capture.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rdata_d = rdata_q;
`ifdef RAM_WORD_SEQ_VERIFY_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          base_d  = req_addr;
          state_d = req_write ? ST_WRITE : ST_READ;
`ifdef RAM_WORD_SEQ_VERIFY_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_READ: begin
        if (last) begin
          rdata_d = word_next;
          state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (last) begin
`ifdef RAM_WORD_SEQ_VERIFY_EN
          state_d = ST_VERIFY;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef RAM_WORD_SEQ_VERIFY_EN
      ST_VERIFY: begin
        if (mismatch) err_d = 1'b1;
        if (last) state_d = ST_DONE;
      end
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM and response registers with synchronous clear; an aborted access never responds.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      rdata_q <= '0;
`ifdef RAM_WORD_SEQ_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rdata_q <= rdata_d;
`ifdef RAM_WORD_SEQ_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_word_seq.sv
// Self-checking bench for ram_word_seq: 64x1 RAM model, a per-cycle
// behavioural schedule model with one compare process, plus directed
// vectors with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_ram_word_seq;

  localparam int W     = 8;
  localparam int A     = 6;
  localparam int DEPTH = 64;
`ifdef RAM_WORD_SEQ_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clear_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [A-1:0] req_addr  = '0;
  logic [W-1:0] req_wdata = '0;
  logic         req_ready, rsp_valid, rsp_err;
  logic [W-1:0] rsp_rdata;
  logic [A-1:0] ram_address;
  logic         ram_datain, ram_store, ram_dataout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_word_seq #(.WORD_W(W), .ADDR_W(A)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .ram_address (ram_address),
    .ram_datain  (ram_datain),
    .ram_store   (ram_store),
    .ram_dataout (ram_dataout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- RAM model (bit 2 optionally stuck at 0 on read) --------
  logic ram_mem [DEPTH];
  bit   stuck2 = 1'b0;
  assign ram_dataout = (stuck2 && ram_address == 2) ? 1'b0 : ram_mem[ram_address];
  always @(posedge clk) if (ram_store) ram_mem[ram_address] <= ram_datain;

  // ---------------- behavioural model -------------------------------------
  // Each accepted request becomes a list of expected per-cycle outputs.
  typedef struct {
    bit           ready, store, datain, valid, is_read, err;
    int           addr;
    logic [W-1:0] rdata;
  } exp_t;

  exp_t         sched[$];
  logic         mem_m [DEPTH];
  logic [W-1:0] exp_rdata = '0;
  bit           armed = 1'b0;

  function automatic bit model_rd(int a);
    return (stuck2 && a == 2) ? 1'b0 : mem_m[a];
  endfunction

  function automatic void build(bit wr, int base, logic [W-1:0] wd);
    exp_t         e;
    bit           err = 1'b0;
    logic [W-1:0] rd  = '0;
    for (int k = 0; k < W; k++) begin
      e = '{default: 0};
      e.addr   = (base + k) % DEPTH;
      e.store  = wr;
      e.datain = wr ? wd[k] : 1'b0;
      if (!wr) rd[k] = model_rd(e.addr);
      sched.push_back(e);
    end
    if (wr && VERIFY_ON) begin
      for (int k = 0; k < W; k++) begin
        e = '{default: 0};
        e.addr = (base + k) % DEPTH;
        if (((stuck2 && e.addr == 2) ? 1'b0 : wd[k]) != wd[k]) err = 1'b1;
        sched.push_back(e);
      end
    end
    e = '{default: 0};
    e.valid   = 1'b1;
    e.is_read = !wr;
    e.rdata   = rd;
    e.err     = err;
    sched.push_back(e);
  endfunction

  // Model advance on each rising edge.
  always @(posedge clk) begin
    exp_t e;
    if (!clear_n) begin
      sched.delete();
      exp_rdata = '0;
      armed     = 1'b1;
    end else if (sched.size() > 0) begin
      e = sched.pop_front();
      if (e.store) mem_m[e.addr] = e.datain;
      if (e.valid && e.is_read) exp_rdata = e.rdata;
    end else if (req_valid) begin
      build(req_write, int'(req_addr), req_wdata);
    end
  end

  // Compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    exp_t c;
    if (armed) begin
      if (sched.size() > 0) c = sched[0];
      else begin
        c = '{default: 0};
        c.ready = 1'b1;
      end
      check("model req_ready", req_ready, c.ready);
      check("model ram_store", ram_store, c.store && clear_n);
      check("model ram_address", ram_address, c.addr);
      check("model ram_datain", ram_datain, c.datain);
      check("model rsp_valid", rsp_valid, c.valid);
      check("model rsp_rdata", rsp_rdata, (c.valid && c.is_read) ? c.rdata : exp_rdata);
      if (c.valid) check("model rsp_err", rsp_err, c.err);
    end
  end

  // ---------------- directed stimulus helpers ------------------------------
  logic         tr_store [64];
  logic [A-1:0] tr_addr  [64];
  logic         tr_din   [64];
  logic         tr_ready [64];

  task automatic start_req(input bit wr, input logic [A-1:0] addr, input logic [W-1:0] wd);
    bit acc = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    for (int t = 0; t < 50 && !acc; t++) begin
      acc = req_ready;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    #1 req_valid = 1'b0;
    if (!acc) check("accept timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int vcyc, output logic [W-1:0] rd, output logic er);
    vcyc = -1; rd = '0; er = 1'b0;
    for (int c = 1; c < 3 * W + 10; c++) begin
      @(negedge clk);
      tr_store[c] = ram_store; tr_addr[c] = ram_address;
      tr_din[c]   = ram_datain; tr_ready[c] = req_ready;
      if (rsp_valid) begin
        vcyc = c; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
    if (vcyc < 0) begin
      check("response timeout", 0, 1);
    end else begin
      @(negedge clk);
      tr_ready[vcyc + 1] = req_ready;
    end
  endtask

  task automatic do_req(input bit wr, input logic [A-1:0] addr, input logic [W-1:0] wd,
                        output int vcyc, output logic [W-1:0] rd, output logic er);
    start_req(wr, addr, wd);
    wait_rsp(vcyc, rd, er);
  endtask

  // ---------------- literal expectations -----------------------------------
  logic a5_bits  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int   wrap_addr[8] = '{60, 61, 62, 63, 0, 1, 2, 3};

  int           vc, n_acc, n_pulse, st_or;
  int           acc_at [4];
  logic [W-1:0] rdv [4];
  logic [W-1:0] rd;
  logic         er;
  bit           rdy;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = 1'b0;
      mem_m[i]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 clear_n = 1'b1;
    @(negedge clk);
    check("reset req_ready", req_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset ram_store", ram_store, 0);
    check("reset ram_address", ram_address, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    check("reset rsp_err", rsp_err, 0);

    // Write 0xA5 at 8
    do_req(1'b1, 6'd8, 8'hA5, vc, rd, er);
    check("wrA5 rsp cycle", vc, 9);
    for (int c = 1; c <= 8; c++) begin
      check("wrA5 store", tr_store[c], 1);
      check("wrA5 address", tr_addr[c], 8 + c - 1);
      check("wrA5 datain", tr_din[c], a5_bits[c - 1]);
    end
    check("wrA5 ready cycle 10", tr_ready[10], 1);

    // Read 8
    do_req(1'b0, 6'd8, 8'h00, vc, rd, er);
    check("rd8 rsp cycle", vc, 9);
    check("rd8 data", rd, 8'hA5);
    st_or = 0;
    for (int c = 1; c <= 9; c++) st_or |= int'(tr_store[c]);
    check("rd8 no store", st_or, 0);

    // Wrap write/read at 60
    do_req(1'b1, 6'd60, 8'h3C, vc, rd, er);
    for (int c = 1; c <= 8; c++) check("wrap wr address", tr_addr[c], wrap_addr[c - 1]);
    do_req(1'b0, 6'd60, 8'h00, vc, rd, er);
    for (int c = 1; c <= 8; c++) check("wrap rd address", tr_addr[c], wrap_addr[c - 1]);
    check("wrap rd data", rd, 8'h3C);

    // Back-to-back: req_valid held high for two reads
    n_acc = 0; n_pulse = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd8;
    for (int c = 0; c < 40; c++) begin
      rdy = req_ready;
      if (rsp_valid && n_pulse < 4) begin
        rdv[n_pulse] = rsp_rdata;
        n_pulse++;
      end
      @(posedge clk);
      if (rdy && req_valid && n_acc < 4) begin
        acc_at[n_acc] = c;
        n_acc++;
        #1;
        if (n_acc == 1) req_addr = 6'd60;
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b accept count", n_acc, 2);
    check("b2b accept spacing", acc_at[1] - acc_at[0], 10);
    check("b2b rsp pulses", n_pulse, 2);
    check("b2b first data", rdv[0], 8'hA5);
    check("b2b second data", rdv[1], 8'h3C);

    // Reset mid-write: 0xFF at 0, clear_n low during cycle 4
    start_req(1'b1, 6'd0, 8'hFF);
    repeat (3) @(posedge clk);
    #1 clear_n = 1'b0;
    @(negedge clk);
    check("midrst store suppressed", ram_store, 0);
    @(posedge clk);
    #1 clear_n = 1'b1;
    @(negedge clk);
    check("midrst ram_store", ram_store, 0);
    check("midrst req_ready", req_ready, 1);
    n_pulse = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) n_pulse++;
    end
    check("midrst no response", n_pulse, 0);
    do_req(1'b0, 6'd0, 8'h00, vc, rd, er);
    check("midrst readback", rd, 8'h07);

    // Verify with RAM bit 2 stuck at 0
    stuck2 = 1'b1;
    do_req(1'b1, 6'd0, 8'hFF, vc, rd, er);
    if (VERIFY_ON) begin
      check("verify rsp cycle", vc, 17);
      check("verify rsp_err", er, 1);
    end else begin
      check("noverify rsp cycle", vc, 9);
      check("noverify rsp_err", er, 0);
    end
    do_req(1'b0, 6'd0, 8'h00, vc, rd, er);
    check("stuck readback", rd, 8'hFB);
    stuck2 = 1'b0;

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
